// File: rtl/fragment_writer.sv
// Fragment writer: bounds check, optional depth test (read/compare/write), then colour write to VRAM.
// VRAM outputs are registered and held until ack; every access is followed by a sel-low gap cycle.
module fragment_writer #(
   parameter int unsigned FB_WIDTH  = 128,
   parameter int unsigned FB_HEIGHT = 128
) (
   input  logic        clk,
   input  logic        reset_i,
   input  logic        frag_valid_i,
   output logic        frag_ready_o,
   input  logic [15:0] frag_x_i,
   input  logic [15:0] frag_y_i,
   input  logic [15:0] frag_depth_i,
   input  logic [15:0] frag_color_i,
   input  logic        is_depth_test_i,
   input  logic [31:0] back_address_i,
   input  logic [31:0] depth_address_i,
   input  logic        vram_ack_i,
   output logic        vram_sel_o,
   output logic        vram_wr_o,
   output logic [3:0]  vram_mask_o,
   output logic [31:0] vram_addr_o,
   input  logic [15:0] vram_data_in_i,
   output logic [15:0] vram_data_out_o,
   output logic        busy_o,
   output logic [31:0] written_count_o,
   output logic [31:0] rejected_count_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DEPTH_RD,
      S_DEPTH_WR,
      S_COLOR_WR,
      S_GAP
   } state_t;

   state_t      r_state, w_state_nxt;
   state_t      r_gap_next, w_gap_next_nxt;

   logic        r_sel, w_sel_nxt;
   logic        r_wr, w_wr_nxt;
   logic [31:0] r_addr, w_addr_nxt;
   logic [15:0] r_data, w_data_nxt;

   logic [31:0] r_depth_addr;
   logic [31:0] r_color_addr;
   logic [15:0] r_depth;
   logic [15:0] r_color;

   logic [31:0] r_written;
   logic [31:0] r_rejected;

   logic        w_load;
   logic        w_inc_written;
   logic        w_inc_rejected;
   logic        w_in_bounds;
   logic [31:0] w_offset;
   logic [31:0] w_depth_addr;
   logic [31:0] w_color_addr;

   assign w_offset     = 32'(frag_y_i) * FB_WIDTH + 32'(frag_x_i);
   assign w_in_bounds  = (32'(frag_x_i) < FB_WIDTH) && (32'(frag_y_i) < FB_HEIGHT);
   assign w_depth_addr = depth_address_i + w_offset;
   assign w_color_addr = back_address_i + w_offset;

   always_ff @(posedge clk) begin
      if (reset_i) begin
         r_state    <= S_IDLE;
         r_gap_next <= S_IDLE;
         r_sel      <= 1'b0;
         r_wr       <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_written  <= '0;
         r_rejected <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_gap_next <= w_gap_next_nxt;
         r_sel      <= w_sel_nxt;
         r_wr       <= w_wr_nxt;
         r_addr     <= w_addr_nxt;
         r_data     <= w_data_nxt;
         if (w_inc_written)  r_written  <= r_written + 32'd1;
         if (w_inc_rejected) r_rejected <= r_rejected + 32'd1;
      end
   end

   // Fragment context is only consumed after acceptance, so it needs no reset.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_depth_addr <= w_depth_addr;
         r_color_addr <= w_color_addr;
         r_depth      <= frag_depth_i;
         r_color      <= frag_color_i;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_gap_next_nxt = r_gap_next;
      w_sel_nxt      = r_sel;
      w_wr_nxt       = r_wr;
      w_addr_nxt     = r_addr;
      w_data_nxt     = r_data;
      w_load         = 1'b0;
      w_inc_written  = 1'b0;
      w_inc_rejected = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (frag_valid_i) begin
               if (!w_in_bounds) begin
                  w_inc_rejected = 1'b1;
               end else begin
                  w_load    = 1'b1;
                  w_sel_nxt = 1'b1;
                  if (is_depth_test_i) begin
                     w_state_nxt = S_DEPTH_RD;
                     w_wr_nxt    = 1'b0;
                     w_addr_nxt  = w_depth_addr;
                     w_data_nxt  = '0;
                  end else begin
                     w_state_nxt = S_COLOR_WR;
                     w_wr_nxt    = 1'b1;
                     w_addr_nxt  = w_color_addr;
                     w_data_nxt  = frag_color_i;
                  end
               end
            end
         end

         S_DEPTH_RD: begin
            if (vram_ack_i) begin
               w_sel_nxt   = 1'b0;
               w_wr_nxt    = 1'b0;
               w_state_nxt = S_GAP;
               // Strictly nearer fragments win; ties keep the stored depth.
               if (r_depth < vram_data_in_i) begin
                  w_gap_next_nxt = S_DEPTH_WR;
               end else begin
                  w_gap_next_nxt = S_IDLE;
                  w_inc_rejected = 1'b1;
               end
            end
         end

         S_DEPTH_WR: begin
            if (vram_ack_i) begin
               w_sel_nxt      = 1'b0;
               w_wr_nxt       = 1'b0;
               w_state_nxt    = S_GAP;
               w_gap_next_nxt = S_COLOR_WR;
            end
         end

         S_COLOR_WR: begin
            if (vram_ack_i) begin
               w_sel_nxt      = 1'b0;
               w_wr_nxt       = 1'b0;
               w_state_nxt    = S_GAP;
               w_gap_next_nxt = S_IDLE;
               w_inc_written  = 1'b1;
            end
         end

         S_GAP: begin
            w_state_nxt = r_gap_next;
            case (r_gap_next)
               S_DEPTH_WR: begin
                  w_sel_nxt  = 1'b1;
                  w_wr_nxt   = 1'b1;
                  w_addr_nxt = r_depth_addr;
                  w_data_nxt = r_depth;
               end
               S_COLOR_WR: begin
                  w_sel_nxt  = 1'b1;
                  w_wr_nxt   = 1'b1;
                  w_addr_nxt = r_color_addr;
                  w_data_nxt = r_color;
               end
               default: begin
                  w_sel_nxt = 1'b0;
               end
            endcase
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_sel_nxt   = 1'b0;
            w_wr_nxt    = 1'b0;
         end
      endcase
   end

   assign frag_ready_o     = (r_state == S_IDLE);
   assign busy_o           = (r_state != S_IDLE);
   assign vram_sel_o       = r_sel;
   assign vram_wr_o        = r_wr;
   assign vram_mask_o      = 4'hF;
   assign vram_addr_o      = r_addr;
   assign vram_data_out_o  = r_data;
   assign written_count_o  = r_written;
   assign rejected_count_o = r_rejected;

endmodule

// File: tb/tb_fragment_writer.sv
// Table-driven bench for fragment_writer: each vector is one fragment with a VRAM responder,
// followed by hand sequences for stray ack and reset during a depth write.
module tb_fragment_writer;

   logic        clk = 1'b0;
   logic        reset_i;
   logic        frag_valid_i;
   logic        frag_ready_o;
   logic [15:0] frag_x_i, frag_y_i, frag_depth_i, frag_color_i;
   logic        is_depth_test_i;
   logic [31:0] back_address_i, depth_address_i;
   logic        vram_ack_i;
   logic        vram_sel_o, vram_wr_o;
   logic [3:0]  vram_mask_o;
   logic [31:0] vram_addr_o;
   logic [15:0] vram_data_in_i, vram_data_out_o;
   logic        busy_o;
   logic [31:0] written_count_o, rejected_count_o;

   fragment_writer #(.FB_WIDTH(128), .FB_HEIGHT(128)) dut (
      .clk(clk), .reset_i(reset_i),
      .frag_valid_i(frag_valid_i), .frag_ready_o(frag_ready_o),
      .frag_x_i(frag_x_i), .frag_y_i(frag_y_i),
      .frag_depth_i(frag_depth_i), .frag_color_i(frag_color_i),
      .is_depth_test_i(is_depth_test_i),
      .back_address_i(back_address_i), .depth_address_i(depth_address_i),
      .vram_ack_i(vram_ack_i), .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o),
      .vram_mask_o(vram_mask_o), .vram_addr_o(vram_addr_o),
      .vram_data_in_i(vram_data_in_i), .vram_data_out_o(vram_data_out_o),
      .busy_o(busy_o),
      .written_count_o(written_count_o), .rejected_count_o(rejected_count_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] x, y, depth, color;
      logic        dt;
      logic [31:0] back, dbase;
      logic [15:0] stored;
      int          lat;
      logic        pulse;
      int          en;
      logic [31:0] ea0, ea1, ea2;
      logic [2:0]  ew;
      logic [15:0] ed0, ed1, ed2;
      int          dw, dr;
   } vec_t;

   vec_t vt[11];
   int   total = 0;
   int   bad = 0;
   int   exp_w = 0;
   int   exp_r = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int          n, wt, nc;
      bit          in_acc, done;
      logic [31:0] la[3], ea[3];
      logic        lw[3];
      logic [15:0] ld[3], ed[3];
      logic [31:0] ca;
      logic        cw;
      logic [15:0] cd;
      n = 0; wt = 0; in_acc = 0; done = 0;
      ca = '0; cw = 0; cd = '0;
      ea[0] = v.ea0; ea[1] = v.ea1; ea[2] = v.ea2;
      ed[0] = v.ed0; ed[1] = v.ed1; ed[2] = v.ed2;

      frag_x_i = v.x; frag_y_i = v.y; frag_depth_i = v.depth; frag_color_i = v.color;
      is_depth_test_i = v.dt; back_address_i = v.back; depth_address_i = v.dbase;
      frag_valid_i = 1'b1;
      @(posedge clk); #1;
      frag_valid_i = 1'b0;
      // scramble everything so any late sampling of inputs shows up in the addresses
      frag_x_i = 16'd1; frag_y_i = 16'd1; frag_depth_i = 16'h0000; frag_color_i = 16'hDEAD;
      is_depth_test_i = ~v.dt; back_address_i = 32'hDEAD0000; depth_address_i = 32'hBEEF0000;

      for (nc = 0; nc < 80 && !done; nc++) begin
         if (vram_ack_i) begin
            vram_ack_i = 1'b0;
            chk($sformatf("v%0d gap_sel", idx), 32'(vram_sel_o), 32'd0);
         end else if (vram_sel_o) begin
            if (!in_acc) begin
               in_acc = 1; wt = v.lat;
               ca = vram_addr_o; cw = vram_wr_o; cd = vram_data_out_o;
               if (n < 3) begin la[n] = ca; lw[n] = cw; ld[n] = cd; end
               n++;
            end else begin
               chk($sformatf("v%0d hold_addr", idx), vram_addr_o, ca);
               chk($sformatf("v%0d hold_wr", idx), 32'(vram_wr_o), 32'(cw));
               chk($sformatf("v%0d hold_data", idx), 32'(vram_data_out_o), 32'(cd));
            end
            if (wt == 0) begin
               vram_ack_i = 1'b1; vram_data_in_i = v.stored; in_acc = 0;
               frag_valid_i = 1'b0;
            end else begin
               wt--;
               frag_valid_i = v.pulse;
            end
         end else if (!busy_o) begin
            done = 1;
         end
         if (!done) begin
            @(posedge clk); #1;
         end
      end
      frag_valid_i = 1'b0;
      vram_ack_i = 1'b0;
      if (!done) chk($sformatf("v%0d timeout", idx), 32'd1, 32'd0);

      exp_w += v.dw;
      exp_r += v.dr;
      chk($sformatf("v%0d n_access", idx), 32'(n), 32'(v.en));
      for (int i = 0; i < 3; i++) begin
         if (i < v.en && i < n) begin
            chk($sformatf("v%0d addr%0d", idx, i), la[i], ea[i]);
            chk($sformatf("v%0d wr%0d", idx, i), 32'(lw[i]), 32'(v.ew[i]));
            if (v.ew[i]) chk($sformatf("v%0d data%0d", idx, i), 32'(ld[i]), 32'(ed[i]));
         end
      end
      chk($sformatf("v%0d written", idx), written_count_o, 32'(exp_w));
      chk($sformatf("v%0d rejected", idx), rejected_count_o, 32'(exp_r));
      chk($sformatf("v%0d ready", idx), 32'(frag_ready_o), 32'd1);
   endtask

   initial begin
      bit found;
      //          x    y    depth    color    dt  back          dbase     stored   lat pulse en  ea0          ea1       ea2       ew      ed0      ed1      ed2      dw dr
      vt[0]  = '{16'd3,   16'd2,   16'h0000, 16'hF0F0, 1'b0, 32'h1000,     32'h0,    16'h0000, 2,  1'b0, 1, 32'h1103,    32'h0,    32'h0,    3'b001, 16'hF0F0, 16'h0,    16'h0,    1, 0};
      vt[1]  = '{16'd3,   16'd2,   16'h2000, 16'h1234, 1'b1, 32'h1000,     32'h8000, 16'h4000, 0,  1'b0, 3, 32'h8103,    32'h8103, 32'h1103, 3'b110, 16'h0,    16'h2000, 16'h1234, 1, 0};
      vt[2]  = '{16'd3,   16'd2,   16'h4000, 16'h1234, 1'b1, 32'h1000,     32'h8000, 16'h4000, 1,  1'b0, 1, 32'h8103,    32'h0,    32'h0,    3'b000, 16'h0,    16'h0,    16'h0,    0, 1};
      vt[3]  = '{16'd128, 16'd0,   16'h0000, 16'h1111, 1'b0, 32'h1000,     32'h0,    16'h0000, 0,  1'b0, 0, 32'h0,       32'h0,    32'h0,    3'b000, 16'h0,    16'h0,    16'h0,    0, 1};
      vt[4]  = '{16'd0,   16'd128, 16'h0000, 16'h1111, 1'b1, 32'h1000,     32'h8000, 16'h0000, 0,  1'b0, 0, 32'h0,       32'h0,    32'h0,    3'b000, 16'h0,    16'h0,    16'h0,    0, 1};
      vt[5]  = '{16'd127, 16'd127, 16'h0000, 16'h7777, 1'b0, 32'h20000,    32'h0,    16'h0000, 1,  1'b0, 1, 32'h23FFF,   32'h0,    32'h0,    3'b001, 16'h7777, 16'h0,    16'h0,    1, 0};
      vt[6]  = '{16'd0,   16'd0,   16'hFFFE, 16'hABCD, 1'b1, 32'h200,      32'h100,  16'hFFFF, 3,  1'b0, 3, 32'h100,     32'h100,  32'h200,  3'b110, 16'h0,    16'hFFFE, 16'hABCD, 1, 0};
      vt[7]  = '{16'd5,   16'd1,   16'h5000, 16'h0000, 1'b1, 32'h0,        32'h8000, 16'h4FFF, 0,  1'b0, 1, 32'h8085,    32'h0,    32'h0,    3'b000, 16'h0,    16'h0,    16'h0,    0, 1};
      vt[8]  = '{16'd1,   16'd0,   16'h0000, 16'hCAFE, 1'b0, 32'hFFFFFFFF, 32'h0,    16'h0000, 0,  1'b0, 1, 32'h0,       32'h0,    32'h0,    3'b001, 16'hCAFE, 16'h0,    16'h0,    1, 0};
      vt[9]  = '{16'd10,  16'd0,   16'h0000, 16'h5555, 1'b0, 32'h40,       32'h0,    16'h0000, 10, 1'b1, 1, 32'h4A,      32'h0,    32'h0,    3'b001, 16'h5555, 16'h0,    16'h0,    1, 0};
      vt[10] = '{16'd2,   16'd0,   16'h0001, 16'h9999, 1'b1, 32'h300,      32'h500,  16'h0002, 2,  1'b1, 3, 32'h502,     32'h502,  32'h302,  3'b110, 16'h0,    16'h0001, 16'h9999, 1, 0};

      reset_i = 1'b1; frag_valid_i = 1'b0; vram_ack_i = 1'b0; vram_data_in_i = '0;
      frag_x_i = '0; frag_y_i = '0; frag_depth_i = '0; frag_color_i = '0;
      is_depth_test_i = 1'b0; back_address_i = '0; depth_address_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst sel", 32'(vram_sel_o), 32'd0);
      chk("rst wr", 32'(vram_wr_o), 32'd0);
      chk("rst mask", 32'(vram_mask_o), 32'hF);
      chk("rst addr", vram_addr_o, 32'd0);
      chk("rst data", 32'(vram_data_out_o), 32'd0);
      chk("rst written", written_count_o, 32'd0);
      chk("rst rejected", rejected_count_o, 32'd0);
      chk("rst busy", 32'(busy_o), 32'd0);
      chk("rst ready", 32'(frag_ready_o), 32'd1);
      reset_i = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 11; i++) run_vec(i, vt[i]);

      // stray ack while idle must not start or count anything
      vram_ack_i = 1'b1;
      @(posedge clk); #1;
      vram_ack_i = 1'b0;
      chk("stray sel", 32'(vram_sel_o), 32'd0);
      chk("stray busy", 32'(busy_o), 32'd0);
      chk("stray written", written_count_o, 32'(exp_w));
      chk("stray rejected", rejected_count_o, 32'(exp_r));

      // reset while the depth write is outstanding
      frag_x_i = 16'd3; frag_y_i = 16'd2; frag_depth_i = 16'h2000; frag_color_i = 16'h0F0F;
      is_depth_test_i = 1'b1; back_address_i = 32'h1000; depth_address_i = 32'h8000;
      frag_valid_i = 1'b1;
      @(posedge clk); #1;
      frag_valid_i = 1'b0;
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         if (vram_ack_i) vram_ack_i = 1'b0;
         else if (vram_sel_o && vram_wr_o) found = 1;
         else if (vram_sel_o) begin vram_ack_i = 1'b1; vram_data_in_i = 16'h4000; end
         if (!found) begin @(posedge clk); #1; end
      end
      chk("mid found depth_wr", 32'(found), 32'd1);
      chk("mid depth_wr addr", vram_addr_o, 32'h8103);
      reset_i = 1'b1;
      @(posedge clk); #1;
      reset_i = 1'b0;
      exp_w = 0; exp_r = 0;
      chk("mid sel", 32'(vram_sel_o), 32'd0);
      chk("mid wr", 32'(vram_wr_o), 32'd0);
      chk("mid busy", 32'(busy_o), 32'd0);
      chk("mid written", written_count_o, 32'd0);
      chk("mid rejected", rejected_count_o, 32'd0);
      run_vec(100, vt[0]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fragment_writer.md
FRAGMENT_WRITER -- requirements
Module: fragment_writer

Interface
REQ-001 Parameter FB_WIDTH, default 128, framebuffer width in pixels.
REQ-002 Parameter FB_HEIGHT, default 128, framebuffer height in pixels.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 frag_valid_i  input  1  fragment offered.
REQ-006 frag_ready_o  output  1  fragment accepted when valid and ready are both high at a clock edge.
REQ-007 frag_x_i, frag_y_i  input  16 each  unsigned pixel coordinates.
REQ-008 frag_depth_i  input  16  unsigned depth; smaller is nearer.
REQ-009 frag_color_i  input  16  pixel colour word.
REQ-010 is_depth_test_i  input  1  enables the depth test; sampled at acceptance.
REQ-011 back_address_i, depth_address_i  input  32 each  colour and depth buffer base word addresses; sampled at acceptance.
REQ-012 vram_ack_i  input  1  VRAM access complete.
REQ-013 vram_sel_o, vram_wr_o  output  1 each  access request; write when wr high, read when low.
REQ-014 vram_mask_o  output  4  byte mask; always 4'hF.
REQ-015 vram_addr_o  output  32  word address.
REQ-016 vram_data_in_i  input  16; vram_data_out_o  output  16.
REQ-017 busy_o  output  1  high whenever state is not IDLE.
REQ-018 written_count_o, rejected_count_o  output  32 each  fragments written / discarded.

Function
REQ-019 States: IDLE, DEPTH_RD, DEPTH_WR, COLOR_WR, GAP; frag_ready_o = (state == IDLE).
REQ-020 On acceptance, x, y, depth, colour, is_depth_test, and both base addresses latch; offset = y*FB_WIDTH + x, computed at 32-bit unsigned width.
REQ-021 Out of bounds (x >= FB_WIDTH or y >= FB_HEIGHT): fragment discarded; no VRAM access; rejected_count_o +1; remains IDLE.
REQ-022 In bounds: next state DEPTH_RD if depth test on, else COLOR_WR; vram_sel_o is high from the cycle after acceptance.
REQ-023 All VRAM outputs are registered; sel, wr, addr, and data_out stay stable until the edge at which vram_ack_i is sampled high.
REQ-024 vram_sel_o drops at the edge after ack; each access ends with at least one cycle with sel low (GAP) before the next access or return to IDLE.
REQ-025 DEPTH_RD: read, wr=0, addr = depth_address + offset; data captured on the ack edge.
REQ-026 Depth test at ack: if frag_depth < captured (strict, unsigned), go to DEPTH_WR; else discard, rejected_count_o +1, return to IDLE through GAP.
REQ-027 DEPTH_WR: write, addr = depth_address + offset, data = frag depth; then COLOR_WR.
REQ-028 COLOR_WR: write, addr = back_address + offset, data = colour; on ack, written_count_o +1, then return to IDLE through GAP.
REQ-029 Base address or parameter input changes after acceptance do not affect the in-flight fragment.
REQ-030 frag_valid_i is ignored while not IDLE; no fragment is lost or duplicated.
REQ-031 Counters wrap modulo 2^32; a stray vram_ack_i with sel low is ignored.
REQ-032 Throughput: one fragment per (accesses + gaps + 1) cycles minimum; no internal wait beyond the ack latency.

Reset
REQ-033 While reset_i is high, at the next edge: state IDLE, vram_sel_o=0, vram_wr_o=0, vram_mask_o=4'hF, vram_addr_o=0, vram_data_out_o=0, both counters 0, busy_o=0.
REQ-034 Reset during an access abandons it; sel is low the cycle after reset is sampled; the fragment is dropped without counting.

Verification
REQ-035 No depth test, x=3, y=2, back=0x1000, colour=0xF0F0, ack after 2 cycles -> one write to 0x1103 with data 0xF0F0, written_count=1, sel low one cycle later, ready high.
REQ-036 Depth test, depth_address=0x8000, stored 0x4000, frag depth 0x2000, x=3, y=2 -> read 0x8103, write 0x8103=0x2000, write to the colour address, in that order, with a sel-low gap between each.
REQ-037 Same as REQ-036 but frag depth 0x4000 (equal) -> only the read occurs; rejected_count=1; no writes.
REQ-038 x=128 with FB_WIDTH=128 -> no sel pulse; rejected_count +1; ready stays high.
REQ-039 Hold ack low for 10 cycles -> addr, data, and sel stable throughout; frag_valid_i pulses during this time are not accepted.
REQ-040 Assert reset_i mid DEPTH_WR -> next cycle sel=0, counters 0, IDLE; a following fragment completes normally.
